// File: rtl/pic_pkg.sv
// Shared constants for the PIC-style register file: address map,
// STATUS bit positions, reset values and the TMR0 inhibit FSM states.
package pic_pkg;

    localparam logic [4:0] ADDR_INDF   = 5'h00;
    localparam logic [4:0] ADDR_TMR0   = 5'h01;
    localparam logic [4:0] ADDR_PCL    = 5'h02;
    localparam logic [4:0] ADDR_STATUS = 5'h03;
    localparam logic [4:0] ADDR_FSR    = 5'h04;
    localparam logic [4:0] ADDR_OSCCAL = 5'h05;
    localparam logic [4:0] ADDR_GPIO   = 5'h06;
    localparam logic [4:0] GPR_BASE    = 5'h10;

    localparam int STATUS_C  = 0;
    localparam int STATUS_DC = 1;
    localparam int STATUS_Z  = 2;

    localparam logic [7:0] TMR0_RST   = 8'h00;
    localparam logic [7:0] STATUS_RST = 8'h18;
    localparam logic [4:0] FSR_RST    = 5'h00;
    localparam logic [7:0] OSCCAL_RST = 8'hFE;
    localparam logic [3:0] GPIO_RST   = 4'h0;
    localparam logic [7:0] RAM_RST    = 8'h00;

    typedef enum logic {
        TMR_RUN,
        TMR_HOLD
    } tmr_state_e;

    function automatic logic is_gpr(input logic [4:0] a);
        return a[4];
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// File-register access bus: address, write data and enable in,
// combinational read data out.
interface reg_file_if;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       we;
    logic [7:0] data_out;

    modport master (
        output addr,
        output data_in,
        output we,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  we,
        output data_out
    );
endinterface

// File: rtl/tmr0_unit.sv
// TMR0 counter with write-triggered tick inhibit (RUN / HOLD FSM).
// Only built when REG_FILE_TMR0_EN is defined.
module tmr0_unit
    import pic_pkg::*;
#(
    parameter int TMR0_INHIBIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_we,
    input  logic [7:0] i_data,
    output logic [7:0] o_tmr
);

    localparam int CW = (TMR0_INHIBIT < 1) ? 1 : $clog2(TMR0_INHIBIT + 1);
    localparam logic [CW-1:0] INH = CW'(TMR0_INHIBIT);

    tmr_state_e    r_state;
    tmr_state_e    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [7:0]    r_tmr;
    logic [7:0]    w_tmr_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TMR_RUN;
            r_cnt   <= '0;
            r_tmr   <= TMR0_RST;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_tmr   <= w_tmr_nx;
        end
    end

    // A write wins over a same-cycle tick and (re)arms the hold count.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tmr_nx   = r_tmr;
        if (i_we) begin
            w_tmr_nx   = i_data;
            w_cnt_nx   = INH;
            w_state_nx = (TMR0_INHIBIT > 0) ? TMR_HOLD : TMR_RUN;
        end else if (i_tick) begin
            case (r_state)
                TMR_RUN: begin
                    w_tmr_nx = r_tmr + 8'd1;
                end
                TMR_HOLD: begin
                    w_cnt_nx = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_state_nx = TMR_RUN;
                    end
                end
                default: begin
                    w_state_nx = TMR_RUN;
                end
            endcase
        end
    end

    assign o_tmr = r_tmr;

endmodule

// File: rtl/reg_file.sv
// 32-entry PIC-style file register map with SFRs and 16 bytes of RAM.
// TMR0 is present only when REG_FILE_TMR0_EN is defined.
module reg_file
    import pic_pkg::*;
#(
    parameter int TMR0_INHIBIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus,
    input  logic       tmr_tick,
    input  logic       flags_we,
    input  logic [2:0] flags_in,
    input  logic [7:0] pcl_in,
    output logic       pcl_we,
    input  logic [3:0] gpio_in,
    output logic [3:0] gpio_out,
    output logic [4:0] fsr_bus,
    output logic [7:0] status_bus
);

    logic [7:0] r_status;
    logic [4:0] r_fsr;
    logic [7:0] r_osccal;
    logic [3:0] r_gpio;
    logic [7:0] r_ram [16];

    logic       w_wr_tmr;
    logic       w_wr_status;
    logic       w_wr_fsr;
    logic       w_wr_osc;
    logic       w_wr_gpio;
    logic       w_wr_gpr;
    logic [7:0] w_tmr;
    logic [7:0] w_rdata;

    assign w_wr_tmr    = bus.we && (bus.addr == ADDR_TMR0);
    assign w_wr_status = bus.we && (bus.addr == ADDR_STATUS);
    assign w_wr_fsr    = bus.we && (bus.addr == ADDR_FSR);
    assign w_wr_osc    = bus.we && (bus.addr == ADDR_OSCCAL);
    assign w_wr_gpio   = bus.we && (bus.addr == ADDR_GPIO);
    assign w_wr_gpr    = bus.we && is_gpr(bus.addr);

`ifdef REG_FILE_TMR0_EN
    tmr0_unit #(
        .TMR0_INHIBIT (TMR0_INHIBIT)
    ) u_tmr0 (
        .clk    (clk),
        .rst    (rst),
        .i_tick (tmr_tick),
        .i_we   (w_wr_tmr),
        .i_data (bus.data_in),
        .o_tmr  (w_tmr)
    );
`else
    logic        w_unused_tmr;
    logic [31:0] w_unused_inh;
    assign w_unused_tmr = tmr_tick ^ w_wr_tmr;
    assign w_unused_inh = TMR0_INHIBIT;
    assign w_tmr        = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= STATUS_RST;
            r_fsr    <= FSR_RST;
            r_osccal <= OSCCAL_RST;
            r_gpio   <= GPIO_RST;
        end else begin
            if (w_wr_status) begin
                r_status[7:3] <= bus.data_in[7:3];
            end
            // ALU flags take priority over a bus write on Z/DC/C.
            if (flags_we) begin
                r_status[STATUS_Z:STATUS_C] <= flags_in;
            end else if (w_wr_status) begin
                r_status[STATUS_Z:STATUS_C] <= bus.data_in[2:0];
            end
            if (w_wr_fsr) begin
                r_fsr <= bus.data_in[4:0];
            end
            if (w_wr_osc) begin
                r_osccal <= bus.data_in;
            end
            if (w_wr_gpio) begin
                r_gpio <= bus.data_in[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_ram[i] <= RAM_RST;
            end
        end else if (w_wr_gpr) begin
            r_ram[bus.addr[3:0]] <= bus.data_in;
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (is_gpr(bus.addr)) begin
            w_rdata = r_ram[bus.addr[3:0]];
        end else begin
            case (bus.addr)
                ADDR_TMR0:   w_rdata = w_tmr;
                ADDR_PCL:    w_rdata = pcl_in;
                ADDR_STATUS: w_rdata = r_status;
                ADDR_FSR:    w_rdata = {3'b111, r_fsr};
                ADDR_OSCCAL: w_rdata = r_osccal;
                ADDR_GPIO:   w_rdata = {4'b0000, gpio_in};
                default:     w_rdata = 8'h00;
            endcase
        end
    end

    assign bus.data_out = w_rdata;
    assign pcl_we       = !rst && bus.we && (bus.addr == ADDR_PCL);
    assign gpio_out     = r_gpio;
    assign fsr_bus      = r_fsr;
    assign status_bus   = r_status;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural register model.
module tb_reg_file;

    localparam int INH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tmr_tick;
    logic       flags_we;
    logic [2:0] flags_in;
    logic [7:0] pcl_in;
    logic       pcl_we;
    logic [3:0] gpio_in;
    logic [3:0] gpio_out;
    logic [4:0] fsr_bus;
    logic [7:0] status_bus;

    reg_file_if bus ();

    reg_file #(
        .TMR0_INHIBIT (INH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .tmr_tick   (tmr_tick),
        .flags_we   (flags_we),
        .flags_in   (flags_in),
        .pcl_in     (pcl_in),
        .pcl_we     (pcl_we),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .fsr_bus    (fsr_bus),
        .status_bus (status_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

`ifdef REG_FILE_TMR0_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    // Behavioural model of the architectural state.
    logic [7:0] m_ram [16];
    logic [7:0] m_tmr;
    int         m_inh;
    logic [7:0] m_status;
    logic [4:0] m_fsr;
    logic [7:0] m_osc;
    logic [3:0] m_gpo;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_tmr    = 8'h00;
        m_inh    = 0;
        m_status = 8'h18;
        m_fsr    = 5'h00;
        m_osc    = 8'hFE;
        m_gpo    = 4'h0;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        if (a >= 16) return m_ram[a-16];
        case (a)
            1:       return TMR_EN ? m_tmr : 8'h00;
            2:       return pcl_in;
            3:       return m_status;
            4:       return {3'b111, m_fsr};
            5:       return m_osc;
            6:       return {4'b0000, gpio_in};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_clock(input int a, input logic [7:0] d,
                                        input logic w, input logic fw,
                                        input logic [2:0] fi,
                                        input logic tk);
        if (w && a == 3) m_status[7:3] = d[7:3];
        if (fw) m_status[2:0] = fi;
        else if (w && a == 3) m_status[2:0] = d[2:0];
        if (w && a == 4) m_fsr = d[4:0];
        if (w && a == 5) m_osc = d;
        if (w && a == 6) m_gpo = d[3:0];
        if (w && a >= 16) m_ram[a-16] = d;
        if (w && a == 1) begin
            m_tmr = d;
            m_inh = INH;
        end else if (tk) begin
            if (m_inh > 0) m_inh = m_inh - 1;
            else m_tmr = 8'((int'(m_tmr) + 1) % 256);
        end
    endfunction

    task automatic drive(input logic [4:0] a, input logic [7:0] d,
                         input logic w, input logic fw,
                         input logic [2:0] fi, input logic tk);
        bus.addr    = a;
        bus.data_in = d;
        bus.we      = w;
        flags_we    = fw;
        flags_in    = fi;
        tmr_tick    = tk;
    endtask

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic       we;
        logic       fwe;
        logic [2:0] fi;
        logic [4:0] ra;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] texp [4];
        rst = 1'b1;
        pcl_in = 8'h5A;
        gpio_in = 4'h9;
        drive(5'h00, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0);

        tbl[0]  = '{5'h13, 8'hA5, 1, 0, 3'b000, 5'h13, 8'hA5, "gpr13"};
        tbl[1]  = '{5'h0A, 8'h77, 1, 0, 3'b000, 5'h0A, 8'h00, "unimp0A"};
        tbl[2]  = '{5'h04, 8'h1F, 1, 0, 3'b000, 5'h04, 8'hFF, "fsr"};
        tbl[3]  = '{5'h03, 8'hE0, 1, 1, 3'b101, 5'h03, 8'hE5, "stat_fl"};
        tbl[4]  = '{5'h00, 8'h33, 1, 0, 3'b000, 5'h00, 8'h00, "indf"};
        tbl[5]  = '{5'h06, 8'hAB, 1, 0, 3'b000, 5'h06, 8'h09, "gpio_rd"};
        tbl[6]  = '{5'h05, 8'h12, 1, 0, 3'b000, 5'h05, 8'h12, "osccal"};
        tbl[7]  = '{5'h1F, 8'h3C, 1, 0, 3'b000, 5'h1F, 8'h3C, "gpr1F"};
        tbl[8]  = '{5'h10, 8'h01, 1, 0, 3'b000, 5'h1F, 8'h3C, "gpr_alias"};
        tbl[9]  = '{5'h03, 8'h00, 0, 1, 3'b010, 5'h03, 8'hE2, "flags_only"};
        tbl[10] = '{5'h03, 8'hFF, 1, 0, 3'b000, 5'h03, 8'hFF, "stat_wr"};
        tbl[11] = '{5'h0F, 8'h99, 1, 0, 3'b000, 5'h0F, 8'h00, "unimp0F"};

        // Reset values, read while rst is held.
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            bus.addr = 5'(a);
            #1;
            chk($sformatf("rst_rd%0h", a), bus.data_out, model_read(a));
        end
        chk("rst_status", status_bus, 8'h18);
        chk("rst_fsr", {3'b000, fsr_bus}, 8'h00);
        chk("rst_gpo", {4'h0, gpio_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].fwe, tbl[i].fi, 0);
            @(negedge clk);
            drive(tbl[i].ra, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0);
            #1;
            chk(tbl[i].nm, bus.data_out, tbl[i].exp);
        end
        chk("fsr_bus", {3'b000, fsr_bus}, 8'h1F);
        chk("gpio_out", {4'h0, gpio_out}, 8'h0B);

        // STATUS write with simultaneous flag update.
        @(negedge clk);
        drive(5'h03, 8'hE0, 1'b1, 1'b1, 3'b101, 1'b0);
        @(negedge clk);
        drive(5'h00, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0);
        #1;
        chk("status_bus", status_bus, 8'hE5);

        // PCL write: one-cycle strobe, read returns pcl_in.
        @(negedge clk);
        pcl_in = 8'hC3;
        drive(5'h02, 8'h40, 1'b1, 1'b0, 3'b000, 1'b0);
        #1;
        chk("pcl_we_hi", {7'd0, pcl_we}, 8'h01);
        chk("pcl_rd", bus.data_out, 8'hC3);
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        chk("pcl_we_lo", {7'd0, pcl_we}, 8'h00);

        // TMR0 load with inhibit, wrap, and reload during hold.
        @(negedge clk);
        drive(5'h01, 8'hFE, 1'b1, 1'b0, 3'b000, 1'b1);
        texp[0] = 8'hFE;
        texp[1] = 8'hFE;
        texp[2] = 8'hFF;
        texp[3] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(5'h01, 8'h00, 1'b0, 1'b0, 3'b000, 1'b1);
            @(negedge clk);
            tmr_tick = 1'b0;
            #1;
            chk($sformatf("tmr_t%0d", k), bus.data_out,
                TMR_EN ? texp[k] : 8'h00);
        end
        @(negedge clk);
        drive(5'h01, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        drive(5'h01, 8'h00, 1'b0, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        drive(5'h01, 8'h20, 1'b1, 1'b0, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(5'h01, 8'h00, 1'b0, 1'b0, 3'b000, 1'b1);
        end
        @(negedge clk);
        tmr_tick = 1'b0;
        #1;
        chk("tmr_reload", bus.data_out, TMR_EN ? 8'h21 : 8'h00);

        // Asynchronous reset in the middle of a write.
        @(negedge clk);
        drive(5'h13, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_status", status_bus, 8'h18);
        chk("arst_fsr", {3'b000, fsr_bus}, 8'h00);
        chk("arst_gpo", {4'h0, gpio_out}, 8'h00);
        chk("arst_osc", dut.r_osccal, 8'hFE);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        model_reset();
        for (int a = 0; a < 32; a++) begin
            bus.addr = 5'(a);
            #1;
            chk($sformatf("arst_rd%0h", a), bus.data_out, model_read(a));
        end
        @(negedge clk);
        rst = 1'b0;
        bus.addr = 5'h13;
        #1;
        chk("wr_discard", bus.data_out, 8'h00);
        @(negedge clk);
        drive(5'h13, 8'h66, 1'b1, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        chk("wr_after_rst", bus.data_out, 8'h66);
        model_clock(5'h13, 8'h66, 1'b1, 1'b0, 3'b000, 1'b0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            int a;
            logic [7:0] d;
            logic w, fw, tk;
            logic [2:0] fi;
            @(negedge clk);
            a  = $urandom_range(0, 31);
            d  = 8'($urandom);
            w  = 1'($urandom);
            fw = ($urandom_range(0, 3) == 0);
            fi = 3'($urandom);
            tk = 1'($urandom);
            pcl_in  = 8'($urandom);
            gpio_in = 4'($urandom);
            drive(5'(a), d, w, fw, fi, tk);
            #2;
            chk("rnd_rd", bus.data_out, model_read(a));
            chk("rnd_pclwe", {7'd0, pcl_we}, {7'd0, w && a == 2});
            chk("rnd_status", status_bus, m_status);
            chk("rnd_fsr", {3'b000, fsr_bus}, {3'b000, m_fsr});
            chk("rnd_gpo", {4'h0, gpio_out}, {4'h0, m_gpo});
            @(posedge clk);
            model_clock(a, d, w, fw, fi, tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
